des_key_schedule: RTL and testbench
===================================

DES_KEY_SCHEDULE -- requirements
Module: des_key_schedule

Interface
REQ-001 SHALL have no parameters; all widths are fixed by DES.
REQ-002 Clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Reset  input  1  reset is synchronous and active-high.
REQ-004 start  input  1  pulse; requests a new 16-subkey sequence for key.
REQ-005 decrypt  input  1  sampled with start; 0 = emit K1..K16, 1 = emit K16..K1.
REQ-006 key  input  64  DES key; bit 63 = DES bit 1 (MSB-first), bits 56,48,...,0 are parity bits; sampled with start.
REQ-007 busy  output  1  high while a sequence is in progress.
REQ-008 subkey  output  48  current round key after PC-2; key bit order is MSB-first, matching key.
REQ-009 subkey_valid  output  1  subkey holds a valid round key.
REQ-010 subkey_ready  input  1  consumer accepts subkey when high with subkey_valid.
REQ-011 round  output  4  DES round number minus 1 (0..15) of the presented subkey.
REQ-012 last  output  1  high with subkey_valid on the 16th subkey of the sequence.
REQ-013 parity_err  output  1  one-cycle pulse on an odd-parity failure (see Configuration).

Function
REQ-014 SHALL implement states IDLE and EMIT.
REQ-015 In IDLE, start=1 SHALL load C,D = PC-1(key) (28+28 bits), latch decrypt, and enter EMIT on the next edge; busy=1 from that edge.
REQ-016 Encrypt load SHALL pre-rotate C,D left by 1 so the first subkey is K1; decrypt load SHALL apply no rotation so the first subkey is K16 (C16D16 = C0D0).
REQ-017 In EMIT, subkey SHALL be PC-2(C,D), combinational from registers; subkey_valid=1.
REQ-018 subkey, round and last SHALL hold stable while subkey_valid=1 and subkey_ready=0.
REQ-019 On subkey_valid and subkey_ready, C,D SHALL advance one step: encrypt rotates left by 1 for next rounds 2, 9, 16 and by 2 otherwise; decrypt rotates right by 1 toward rounds 15, 8, 1 and by 2 otherwise.
REQ-020 A new subkey SHALL be presented on the cycle after each acceptance, giving at most 1 subkey per cycle; 16 consecutive cycles with ready held high.
REQ-021 round SHALL count 0..15 in encrypt and 15..0 in decrypt; last=1 on the 16th subkey in either direction.
REQ-022 Acceptance with last=1 SHALL return to IDLE; busy and subkey_valid SHALL be 0 on the next cycle.
REQ-023 start SHALL be ignored while busy=1; start in the same cycle as the final acceptance SHALL be ignored.
REQ-024 Changes on key or decrypt SHALL have no effect outside the start cycle in IDLE.

Reset
REQ-025 Reset SHALL force IDLE; busy=0, subkey_valid=0, last=0, parity_err=0, round=0, C=D=0, subkey=0.
REQ-026 Reset mid-sequence SHALL abort immediately; no further subkeys SHALL be presented until a new start.
REQ-027 Reset SHALL take priority over start and subkey_ready in the same cycle.

Configuration
REQ-028 Macro DES_KS_PARITY_CHK_EN defined: at start in IDLE, every key byte SHALL be checked for odd parity. On any failure, parity_err SHALL pulse for 1 cycle, the block SHALL stay in IDLE, and no subkeys SHALL be emitted.
REQ-029 Macro undefined: parity_err SHALL be tied 0 and parity bits SHALL be ignored.

Verification
REQ-030 key=133457799BBCDFF1, decrypt=0, ready held 1 -> K1=1B02EFFC7072 at round 0, K2=79AED9DBC9E5 at round 1, K16=CB3D8B0E17F5 at round 15 with last=1; 16 consecutive valid cycles.
REQ-031 Same key, decrypt=1 -> first subkey CB3D8B0E17F5 at round 15, last subkey 1B02EFFC7072 at round 0 with last=1; full sequence equals the encrypt sequence reversed.
REQ-032 Encrypt run with ready toggled pseudo-randomly -> subkey/round held while stalled; exact 16-key sequence; start pulses during busy ignored.
REQ-033 Reset asserted after 5 accepted subkeys -> next cycle busy=0 and subkey_valid=0; new start with decrypt=1 yields CB3D8B0E17F5 first.
REQ-034 key=133457799BBCDFF0 -> with DES_KS_PARITY_CHK_EN, parity_err pulses 1 cycle and busy stays 0; without the macro, subkeys are identical to REQ-030.

Source files
------------

// File: rtl/des_key_schedule.sv
`default_nettype none
// ============================================================================
// Module   : des_key_schedule
// Brief    : DES round-key generator, one PC-2 subkey per accepted handshake,
//            forward (K1..K16) or reverse (K16..K1). Optional odd-parity key
//            check enabled by macro DES_KS_PARITY_CHK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module des_key_schedule (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        decrypt,
    input  logic [63:0] key,
    output logic        busy,
    output logic [47:0] subkey,
    output logic        subkey_valid,
    input  logic        subkey_ready,
    output logic [3:0]  round,
    output logic        last,
    output logic        parity_err
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_EMIT = 1'b1
    } state_t;

    // DES bit numbers, 1 = MSB
    localparam int PC1_TBL [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2_TBL [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    function automatic logic [55:0] pc1(input logic [63:0] k);
        logic [55:0] r;
        for (int i = 0; i < 56; i++) r[55-i] = k[64-PC1_TBL[i]];
        return r;
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] cd);
        logic [47:0] r;
        for (int i = 0; i < 48; i++) r[47-i] = cd[56-PC2_TBL[i]];
        return r;
    endfunction

    function automatic logic [27:0] rotl(input logic [27:0] x, input logic two);
        return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
    endfunction

    function automatic logic [27:0] rotr(input logic [27:0] x, input logic two);
        return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
    endfunction

    state_t      r_state;
    logic [27:0] r_c;
    logic [27:0] r_d;
    logic        r_dec;
    logic [3:0]  r_round;
    logic        r_parity_err;

    logic [55:0] w_pc1;
    logic        w_single;
    logic        w_last;
    logic        w_valid;
    logic        w_parity_ok;

    assign w_pc1 = pc1(key);

`ifdef DES_KS_PARITY_CHK_EN
    always_comb begin
        w_parity_ok = 1'b1;
        for (int b = 0; b < 8; b++) begin
            if (!(^key[8*b +: 8])) w_parity_ok = 1'b0;
        end
    end
`else
    logic w_unused_parity;
    assign w_parity_ok     = 1'b1;
    assign w_unused_parity = ^{key[56], key[48], key[40], key[32],
                               key[24], key[16], key[8], key[0]};
`endif

    // Forward: single shift entering rounds 2, 9, 16; reverse undoes the
    // shift of the current round (rounds 16, 9, 2 are single shifts).
    assign w_single = r_dec ? (r_round == 4'd15 || r_round == 4'd8 || r_round == 4'd1)
                            : (r_round == 4'd0  || r_round == 4'd7 || r_round == 4'd14);
    assign w_last   = r_dec ? (r_round == 4'd0) : (r_round == 4'd15);
    assign w_valid  = (r_state == S_EMIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_c          <= '0;
            r_d          <= '0;
            r_dec        <= 1'b0;
            r_round      <= '0;
            r_parity_err <= 1'b0;
        end else begin
            r_parity_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (!w_parity_ok) begin
                            r_parity_err <= 1'b1;
                        end else begin
                            r_dec   <= decrypt;
                            r_state <= S_EMIT;
                            if (decrypt) begin
                                r_c     <= w_pc1[55:28];
                                r_d     <= w_pc1[27:0];
                                r_round <= 4'd15;
                            end else begin
                                r_c     <= rotl(w_pc1[55:28], 1'b0);
                                r_d     <= rotl(w_pc1[27:0], 1'b0);
                                r_round <= 4'd0;
                            end
                        end
                    end
                end
                S_EMIT: begin
                    if (subkey_ready) begin
                        if (w_last) begin
                            r_state <= S_IDLE;
                        end else if (r_dec) begin
                            r_c     <= rotr(r_c, !w_single);
                            r_d     <= rotr(r_d, !w_single);
                            r_round <= r_round - 4'd1;
                        end else begin
                            r_c     <= rotl(r_c, !w_single);
                            r_d     <= rotl(r_d, !w_single);
                            r_round <= r_round + 4'd1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy         = w_valid;
    assign subkey_valid = w_valid;
    assign subkey       = w_valid ? pc2({r_c, r_d}) : '0;
    assign round        = r_round;
    assign last         = w_valid & w_last;
    assign parity_err   = r_parity_err;

endmodule
`default_nettype wire

// File: tb/tb_des_key_schedule.sv
`default_nettype none
// ============================================================================
// Module   : tb_des_key_schedule
// Brief    : Directed self-checking bench for des_key_schedule.
// Revision : 1.0 - initial release
// ============================================================================
module tb_des_key_schedule;

    localparam logic [63:0] KEY_GOOD = 64'h133457799BBCDFF1;
    localparam logic [63:0] KEY_BADP = 64'h133457799BBCDFF0;

    localparam logic [47:0] KS [16] = '{
        48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
        48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
        48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
        48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
    };

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        decrypt = 1'b0;
    logic [63:0] key = '0;
    logic        busy;
    logic [47:0] subkey;
    logic        subkey_valid;
    logic        subkey_ready = 1'b0;
    logic [3:0]  round;
    logic        last;
    logic        parity_err;

    int tests_run = 0;
    int tests_failed = 0;

    des_key_schedule dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .decrypt      (decrypt),
        .key          (key),
        .busy         (busy),
        .subkey       (subkey),
        .subkey_valid (subkey_valid),
        .subkey_ready (subkey_ready),
        .round        (round),
        .last         (last),
        .parity_err   (parity_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"},  64'(busy), 64'd0);
        check({tag, "_valid"}, 64'(subkey_valid), 64'd0);
        check({tag, "_last"},  64'(last), 64'd0);
    endtask

    task automatic run_seq(input logic [63:0] k, input logic dec, input string tag);
        int r;
        start        = 1'b1;
        key          = k;
        decrypt      = dec;
        subkey_ready = 1'b1;
        tick();
        start   = 1'b0;
        key     = 64'hDEADBEEFCAFEF00D;
        decrypt = ~dec;
        for (int i = 0; i < 16; i++) begin
            r = dec ? 15 - i : i;
            check($sformatf("%s_valid%0d", tag, i),  64'(subkey_valid), 64'd1);
            check($sformatf("%s_key%0d", tag, i),    64'(subkey), 64'(KS[r]));
            check($sformatf("%s_round%0d", tag, i),  64'(round), 64'(r));
            check($sformatf("%s_last%0d", tag, i),   64'(last), 64'(i == 15));
            tick();
        end
        check_idle({tag, "_end"});
        subkey_ready = 1'b0;
    endtask

    initial begin : main
        logic [7:0] lfsr;
        int         idx;
        int         cyc;
        logic       acc;

        tick();
        tick();
        rst = 1'b0;
        check_idle("rst");
        check("rst_round",  64'(round), 64'd0);
        check("rst_subkey", 64'(subkey), 64'd0);
        check("rst_perr",   64'(parity_err), 64'd0);

        run_seq(KEY_GOOD, 1'b0, "enc");
        run_seq(KEY_GOOD, 1'b1, "dec");

        // Random stalls, with conflicting start requests while busy
        lfsr         = 8'hA5;
        start        = 1'b1;
        key          = KEY_GOOD;
        decrypt      = 1'b0;
        subkey_ready = 1'b0;
        tick();
        key     = 64'hFFFFFFFFFFFFFFFF;
        decrypt = 1'b1;
        idx     = 0;
        cyc     = 0;
        while (idx < 16 && cyc < 300) begin
            check($sformatf("stall_valid%0d", cyc), 64'(subkey_valid), 64'd1);
            check($sformatf("stall_key%0d", cyc),   64'(subkey), 64'(KS[idx]));
            check($sformatf("stall_round%0d", cyc), 64'(round), 64'(idx));
            lfsr         = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            subkey_ready = lfsr[0];
            start        = (idx == 15) ? 1'b1 : lfsr[1];
            acc          = subkey_ready;
            tick();
            if (acc) idx++;
            cyc++;
        end
        check("stall_done", 64'(idx), 64'd16);
        check_idle("stall_end");
        start        = 1'b0;
        subkey_ready = 1'b0;
        tick();
        check_idle("stall_after");

        // Reset after five accepted subkeys, asserted together with start
        start        = 1'b1;
        key          = KEY_GOOD;
        decrypt      = 1'b0;
        subkey_ready = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("mid_round", 64'(round), 64'd5);
        check("mid_key",   64'(subkey), 64'(KS[5]));
        rst   = 1'b1;
        start = 1'b1;
        tick();
        rst   = 1'b0;
        start = 1'b0;
        check_idle("abort");
        check("abort_subkey", 64'(subkey), 64'd0);
        check("abort_round",  64'(round), 64'd0);
        tick();
        check_idle("abort2");
        run_seq(KEY_GOOD, 1'b1, "postrst");

`ifdef DES_KS_PARITY_CHK_EN
        start   = 1'b1;
        key     = KEY_BADP;
        decrypt = 1'b0;
        tick();
        start = 1'b0;
        check("perr_pulse", 64'(parity_err), 64'd1);
        check_idle("perr");
        tick();
        check("perr_clear", 64'(parity_err), 64'd0);
        check_idle("perr2");
        tick();
        check_idle("perr3");
        run_seq(KEY_GOOD, 1'b0, "perr_ok");
`else
        run_seq(KEY_BADP, 1'b0, "noperr");
        check("noperr_perr", 64'(parity_err), 64'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
